store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 12 +
 rtl/store_buffer_if.sv | 30 +++
 rtl/store_buffer_match.sv | 29 ++
 rtl/store_buffer.sv | 114 +++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared widths, stall code and entry layout for the store buffer.
// Imported by the interface, the match search and the top.
package sb_pkg;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam logic [2:0] STALL_WB = 3'd6;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// Core-side store/load port and memory-side write/read port of the store buffer.
// Load addresses carry the valid flag in bit 16 and the word address in bits [15:1].
interface store_buffer_if;
    import sb_pkg::*;

    logic                st_wen;
    logic [ADDR_W-1:0]   st_waddr;
    logic [DATA_W-1:0]   st_wdata;
    logic [16:1]         ld_raddr;
    logic [DATA_W-1:0]   ld_rdata;
    logic [2:0]          stall_num;
    logic                sb_empty;
    logic                mem_wen;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_busy;
    logic [16:1]         mem_raddr;
    logic [DATA_W-1:0]   mem_rdata;

    // The store buffer itself sits on the slave side.
    modport slave (
        input  st_wen, st_waddr, st_wdata, ld_raddr, mem_busy, mem_rdata,
        output ld_rdata, stall_num, sb_empty, mem_wen, mem_waddr, mem_wdata, mem_raddr
    );

    modport master (
        output st_wen, st_waddr, st_wdata, ld_raddr, mem_busy, mem_rdata,
        input  ld_rdata, stall_num, sb_empty, mem_wen, mem_waddr, mem_wdata, mem_raddr
    );
endinterface

// File: rtl/store_buffer_match.sv
// Youngest-match search over the buffered stores for load forwarding.
// Walking oldest to youngest lets later hits overwrite earlier ones.
module sb_match
    import sb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] entries_i,
    input  logic [DEPTH-1:0]      valid_i,
    input  logic [PTR_W-1:0]      head_i,
    input  logic [ADDR_W-1:0]     addr_i,
    output logic                  hit_o,
    output logic [DATA_W-1:0]     data_o
);

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_i[head_i + PTR_W'(k)] &&
                entries_i[head_i + PTR_W'(k)].addr == addr_i) begin
                hit_o  = 1'b1;
                data_o = entries_i[head_i + PTR_W'(k)].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Circular FIFO store buffer between core and memory with load forwarding.
// Stores drain in order whenever memory is free; loads see the youngest buffered value.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    store_buffer_if.slave sb_io
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    sb_entry_t [DEPTH-1:0] entries_q;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  fwdHit_q, fwdHit_d;
    logic [DATA_W-1:0]     fwdData_q, fwdData_d;

    logic                  full;
    logic                  drain;
    logic                  push;
    logic [DEPTH-1:0]      validMask;
    logic                  bufHit;
    logic [DATA_W-1:0]     bufData;

    assign full  = (count_q == FULL_CNT);
    assign drain = (count_q != '0) && !sb_io.mem_busy;
    // A full buffer still accepts a store when the head leaves in the same cycle.
    assign push  = sb_io.st_wen && (!full || drain);

    always_comb begin
        validMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            validMask[i] = {1'b0, PTR_W'(PTR_W'(i) - head_q)} < count_q;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (drain) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({push, drain})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    sb_match #(.DEPTH(DEPTH)) u_match (
        .entries_i (entries_q),
        .valid_i   (validMask),
        .head_i    (head_q),
        .addr_i    (sb_io.ld_raddr[15:1]),
        .hit_o     (bufHit),
        .data_o    (bufData)
    );

    // The store accepted this cycle is younger than anything already buffered.
    always_comb begin
        fwdHit_d  = 1'b0;
        fwdData_d = '0;
        if (sb_io.ld_raddr[16]) begin
            if (push && sb_io.st_waddr == sb_io.ld_raddr[15:1]) begin
                fwdHit_d  = 1'b1;
                fwdData_d = sb_io.st_wdata;
            end else if (bufHit) begin
                fwdHit_d  = 1'b1;
                fwdData_d = bufData;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            fwdHit_q  <= 1'b0;
            fwdData_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            fwdHit_q  <= fwdHit_d;
            fwdData_q <= fwdData_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[tail_q] <= '{addr: sb_io.st_waddr, data: sb_io.st_wdata};
        end
    end

    assign sb_io.stall_num = (sb_io.st_wen && full && sb_io.mem_busy) ? STALL_WB : 3'd0;
    assign sb_io.sb_empty  = (count_q == '0);
    assign sb_io.mem_wen   = drain;
    assign sb_io.mem_waddr = entries_q[head_q].addr;
    assign sb_io.mem_wdata = entries_q[head_q].data;
    assign sb_io.mem_raddr = sb_io.ld_raddr;
    assign sb_io.ld_rdata  = fwdHit_q ? fwdData_q : sb_io.mem_rdata;

endmodule
